// File: rtl/mbus_pkg.sv
// Memory bus controller shared types: FSM state encoding and timeout default.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mbus_pkg;

  // Bus handshake phases; IDLE is zero so reset and decode stay trivial.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } mbus_state_t;

  // Default no-answer limit in REQ cycles, and width of the counter behind it.
  localparam int TIMEOUT_DEF = 200;
  localparam int TMO_W       = 8;

endpackage

// File: rtl/mbus_tmo.sv
// No-answer watchdog: counts REQ cycles and flags the cycle that reaches TIMEOUT.
// Latency: expire is combinational from the counter and qualified by en (the Nth en cycle).
// Backpressure: none; clr restarts the count, en advances it.
module mbus_tmo
  import mbus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic __clk,
  input  logic __rst_,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TMO_W-1:0] cnt;

  // Count enabled cycles since the last clear; the first enabled cycle sees 0.
  always_ff @(posedge __clk or negedge __rst_) begin
    if (!__rst_) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Count value TIMEOUT-1 means this is the TIMEOUT-th waiting cycle.
  assign expire = en && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mbus_ctl.sv
// Memory bus master: latches an ALU read/write, runs REQ/DROP handshake, returns read data.
// Latency: start edge -> REQ next cycle; done/alarm pulse the cycle after m_ok/m_en is seen.
// Backpressure: rd/wr are ignored while busy; DROP holds until responder releases m_ok/m_en.
// Build option: define MBUS_TIMEOUT_EN to enable the no-answer watchdog (TIMEOUT cycles).
module mbus_ctl
  import mbus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        __clk,
  input  logic        __rst_,
  input  logic        rd,
  input  logic        wr,
  input  logic [0:15] dad,
  input  logic [0:15] ddt,
  input  logic [0:3]  nb,
  input  logic        m_ok,
  input  logic        m_en,
  output logic        m_req,
  output logic        m_w,
  output logic [0:15] m_ad,
  output logic [0:15] m_dt,
  output logic [0:3]  m_nb,
  input  logic [0:15] m_rdt,
  output logic [0:15] rdt,
  output logic        busy,
  output logic        done,
  output logic        alarm
);

  mbus_state_t state, state_nx;
  logic        start;
  logic        rd_cap;
  logic        done_nx;
  logic        alarm_nx;
  logic        tmo_exp;

`ifdef MBUS_TIMEOUT_EN
  mbus_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .__clk  (__clk),
    .__rst_ (__rst_),
    .clr    (start),
    .en     (state == REQ),
    .expire (tmo_exp)
  );
`else
  // Without the watchdog REQ waits forever; TIMEOUT is kept only for a uniform interface.
  logic [7:0] tmo_unused;
  assign tmo_unused = 8'(TIMEOUT);
  assign tmo_exp    = 1'b0;
`endif

  // State register; reset aborts any transaction on the spot.
  always_ff @(posedge __clk or negedge __rst_) begin
    if (!__rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and pulse decode; m_en takes priority over m_ok, timeout is last resort.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    rd_cap   = 1'b0;
    done_nx  = 1'b0;
    alarm_nx = 1'b0;
    case (state)
      IDLE: begin
        if (rd || wr) begin
          start    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (m_en) begin
          alarm_nx = 1'b1;
          state_nx = DROP;
        end else if (m_ok) begin
          done_nx  = 1'b1;
          rd_cap   = !m_w;
          state_nx = DROP;
        end else if (tmo_exp) begin
          alarm_nx = 1'b1;
          state_nx = DROP;
        end
      end
      DROP: begin
        if (!m_ok && !m_en) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latches (only on accepted start) plus read data and status pulses.
  always_ff @(posedge __clk or negedge __rst_) begin
    if (!__rst_) begin
      m_w   <= 1'b0;
      m_ad  <= '0;
      m_dt  <= '0;
      m_nb  <= '0;
      rdt   <= '0;
      done  <= 1'b0;
      alarm <= 1'b0;
    end else begin
      if (start) begin
        // A coincident rd is dropped in favour of the write.
        m_w  <= wr;
        m_ad <= dad;
        m_nb <= nb;
        m_dt <= wr ? ddt : '0;
      end
      if (rd_cap) begin
        rdt <= m_rdt;
      end
      done  <= done_nx;
      alarm <= alarm_nx;
    end
  end

  // Bus request and busy decode straight from the state flops, no input paths.
  assign m_req = (state == REQ);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mbus_ctl.sv
// Directed bench for mbus_ctl: write, read, error, coincident start, watchdog, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_mbus_ctl;

  logic        __clk = 1'b0;
  logic        __rst_;
  logic        rd, wr;
  logic [0:15] dad, ddt;
  logic [0:3]  nb;
  logic        m_ok, m_en;
  logic        m_req, m_w;
  logic [0:15] m_ad, m_dt;
  logic [0:3]  m_nb;
  logic [0:15] m_rdt;
  logic [0:15] rdt;
  logic        busy, done, alarm;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int alarm_cnt = 0;
  int req_cnt  = 0;
  int d0, a0, r0;

  mbus_ctl #(.TIMEOUT(10)) dut (
    .__clk  (__clk),
    .__rst_ (__rst_),
    .rd     (rd),
    .wr     (wr),
    .dad    (dad),
    .ddt    (ddt),
    .nb     (nb),
    .m_ok   (m_ok),
    .m_en   (m_en),
    .m_req  (m_req),
    .m_w    (m_w),
    .m_ad   (m_ad),
    .m_dt   (m_dt),
    .m_nb   (m_nb),
    .m_rdt  (m_rdt),
    .rdt    (rdt),
    .busy   (busy),
    .done   (done),
    .alarm  (alarm)
  );

  always #5 __clk = ~__clk;

  // Mid-cycle pulse/request counters.
  always @(negedge __clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (alarm) alarm_cnt <= alarm_cnt + 1;
    if (m_req) req_cnt   <= req_cnt + 1;
  end

  task automatic tick();
    @(posedge __clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    d0 = done_cnt;
    a0 = alarm_cnt;
    r0 = req_cnt;
  endtask

  initial begin
    __rst_ = 1'b0;
    rd = 0; wr = 0; dad = '0; ddt = '0; nb = '0;
    m_ok = 0; m_en = 0; m_rdt = '0;
    tick(); tick();
    chk("rst_req",  {m_req, m_w, busy, done, alarm}, 0);
    chk("rst_data", {m_ad, m_dt}, 0);
    chk("rst_nb_rdt", {m_nb, rdt}, 0);
    __rst_ = 1'b1;
    tick();

    // Write, m_ok during third REQ cycle.
    snap();
    wr = 1; dad = 16'h1234; ddt = 16'hABCD; nb = 4'h3;
    tick();
    wr = 0; dad = '0; ddt = '0; nb = '0;
    chk("wr_req", {m_req, m_w, busy}, 3'b111);
    chk("wr_ad", m_ad, 16'h1234);
    chk("wr_dt", m_dt, 16'hABCD);
    chk("wr_nb", m_nb, 4'h3);
    tick();
    tick();
    m_ok = 1;
    tick();
    m_ok = 0;
    chk("wr_drop", {m_req, busy, done}, 3'b011);
    tick();
    chk("wr_idle", {busy, done}, 0);
    chk("wr_req_cycles", req_cnt - r0, 3);
    chk("wr_done_once", done_cnt - d0, 1);
    chk("wr_no_alarm", alarm_cnt - a0, 0);

    // Read with data returned.
    snap();
    rd = 1; dad = 16'h0100; ddt = 16'hFFFF;
    tick();
    rd = 0; dad = '0; ddt = '0;
    chk("rd_req", {m_req, m_w}, 2'b10);
    chk("rd_ad", m_ad, 16'h0100);
    chk("rd_dt_zero", m_dt, 0);
    m_ok = 1; m_rdt = 16'h5A5A;
    tick();
    m_ok = 0; m_rdt = '0;
    chk("rd_rdt", rdt, 16'h5A5A);
    chk("rd_done", done, 1);
    tick();
    chk("rd_idle", busy, 0);
    chk("rd_done_once", done_cnt - d0, 1);

    // Read answered with error; m_ok coincident must be ignored.
    snap();
    rd = 1;
    tick();
    rd = 0;
    m_en = 1; m_ok = 1; m_rdt = 16'hFFFF;
    tick();
    m_ok = 0;
    chk("en_alarm", {alarm, done, m_req, busy}, 4'b1001);
    chk("en_rdt_hold", rdt, 16'h5A5A);
    tick(); tick();
    chk("en_drop_hold", {m_req, busy, alarm}, 3'b010);
    m_en = 0; m_rdt = '0;
    tick();
    chk("en_idle", busy, 0);
    chk("en_alarm_once", alarm_cnt - a0, 1);
    chk("en_no_done", done_cnt - d0, 0);

    // rd and wr together: write wins; later pulses while busy are ignored.
    rd = 1; wr = 1; dad = 16'hBEEF; ddt = 16'h1111; nb = 4'h5;
    tick();
    wr = 0; dad = 16'h2222; ddt = 16'h0000; nb = 4'h0;
    chk("rw_write", {m_w, m_dt}, {1'b1, 16'h1111});
    tick();
    rd = 0;
    chk("busy_rd_ign", {m_ad, m_nb, m_w}, {16'hBEEF, 4'h5, 1'b1});
    m_ok = 1; m_rdt = 16'hDEAD;
    tick();
    wr = 1; dad = 16'h3333;
    tick();
    wr = 0; dad = '0;
    chk("drop_wr_ign", {m_ad, busy, m_req}, {16'hBEEF, 1'b1, 1'b0});
    chk("wr_rdt_hold", rdt, 16'h5A5A);
    m_ok = 0; m_rdt = '0;
    tick();
    chk("rw_idle", busy, 0);

    // No answer at all.
    snap();
    rd = 1;
    tick();
    rd = 0;
`ifdef MBUS_TIMEOUT_EN
    for (int i = 0; i < 9; i++) tick();
    chk("tmo_req_10th", m_req, 1);
    tick();
    chk("tmo_alarm", {alarm, m_req, busy}, 3'b101);
    chk("tmo_req_cycles", req_cnt - r0, 10);
    tick();
    chk("tmo_idle", {busy, alarm}, 0);
`else
    for (int i = 0; i < 1000; i++) tick();
    chk("notmo_held", req_cnt - r0, 1000);
    chk("notmo_no_alarm", {m_req, alarm_cnt - a0}, {1'b1, 32'd0});
    m_ok = 1;
    tick();
    m_ok = 0;
    tick();
    chk("notmo_idle", busy, 0);
`endif

    // Reset two cycles into REQ.
    snap();
    rd = 1;
    tick();
    rd = 0;
    tick();
    chk("pre_rst_req", m_req, 1);
    __rst_ = 1'b0;
    #1;
    chk("rst_async", {m_req, busy}, 0);
    tick(); tick();
    chk("rst_rdt_clr", rdt, 0);
    chk("rst_no_pulse", (done_cnt - d0) + (alarm_cnt - a0), 0);
    __rst_ = 1'b1;
    tick();
    rd = 1; dad = 16'h0042;
    tick();
    rd = 0; dad = '0;
    chk("post_rst_ad", {m_req, m_ad}, {1'b1, 16'h0042});
    m_ok = 1; m_rdt = 16'h7777;
    tick();
    m_ok = 0; m_rdt = '0;
    chk("post_rst_rdt", {done, rdt}, {1'b1, 16'h7777});
    tick();
    chk("post_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mbus_ctl.md
MBUS_CTL -- requirements
Module: mbus_ctl

Interface
REQ-001 Parameter TIMEOUT, default 200, meaning: cycles from request assertion to no-answer alarm (valid 2..255).
REQ-002 __clk  in  1  sole clock, all state on rising edge.
REQ-003 __rst_  in  1  asynchronous active-low reset.
REQ-004 rd  in  1  single-cycle read start pulse from control.
REQ-005 wr  in  1  single-cycle write start pulse from control.
REQ-006 dad  in  16 [0:15]  address from ALU unit.
REQ-007 ddt  in  16 [0:15]  write data from ALU unit.
REQ-008 nb  in  4 [0:3]  memory block number.
REQ-009 m_ok  in  1  responder acknowledge.
REQ-010 m_en  in  1  responder error (no memory).
REQ-011 m_req  out  1  bus request.
REQ-012 m_w  out  1  write qualifier, 1 = write.
REQ-013 m_ad  out  16 [0:15]  latched address.
REQ-014 m_dt  out  16 [0:15]  latched write data, 0 on reads.
REQ-015 m_nb  out  4 [0:3]  latched block number.
REQ-016 m_rdt  in  16 [0:15]  read data from responder.
REQ-017 rdt  out  16 [0:15]  latched read data to ALU unit.
REQ-018 busy  out  1  transaction in progress.
REQ-019 done  out  1  one-cycle pulse, transaction complete.
REQ-020 alarm  out  1  one-cycle pulse, m_en or timeout.

Function
REQ-021 States: IDLE, REQ, DROP; encoding in package.
REQ-022 IDLE: rd or wr latches dad/ddt/nb/direction, next REQ; wr wins if rd and wr coincide (read dropped).
REQ-023 rd/wr in REQ or DROP ignored, no latching.
REQ-024 REQ: m_req=1, m_ad/m_nb/m_dt/m_w stable all state.
REQ-025 REQ + m_ok: read latches m_rdt into rdt same edge; next DROP; done pulses on that edge's following cycle.
REQ-026 REQ + m_en (m_ok ignored if both): next DROP, alarm pulse, rdt unchanged.
REQ-027 DROP: m_req=0; stays until m_ok=0 and m_en=0, then IDLE.
REQ-028 busy=1 in REQ and DROP; 0 in IDLE.
REQ-029 Minimum transaction: start edge, >=1 cycle REQ, >=1 cycle DROP; back-to-back start accepted first IDLE cycle.
REQ-030 m_dt=0 when m_w=0; outputs registered, no combinational path input->output.
REQ-031 rdt holds value until next successful read.

Reset
REQ-032 __rst_ low: state IDLE, m_req/m_w/done/alarm/busy=0, m_ad/m_dt/m_nb/rdt=0, timeout counter 0.
REQ-033 Reset mid-transaction aborts immediately, m_req drops asynchronously, no done/alarm emitted.

Configuration
REQ-034 Macro MBUS_TIMEOUT_EN defined: 8-bit counter cleared on REQ entry, increments each REQ cycle; at TIMEOUT cycles without m_ok/m_en -> alarm pulse, next DROP.
REQ-035 Macro absent: no counter, REQ waits indefinitely; TIMEOUT parameter unused.

Structure
REQ-036 Package mbus_pkg: state typedef/encoding, TIMEOUT default constant.
REQ-037 Sub-module mbus_tmo (timeout counter, clear/enable/expire), instantiated only under MBUS_TIMEOUT_EN.

Verification
REQ-038 wr, dad=16'h1234, ddt=16'hABCD, nb=4'h3; m_ok after 3 cycles -> m_req 3 cycles, m_w=1, m_dt=16'hABCD, done once, alarm 0.
REQ-039 rd, dad=16'h0100; m_ok with m_rdt=16'h5A5A -> rdt=16'h5A5A, m_dt=0, done once.
REQ-040 rd; m_en asserted -> alarm once, no done, rdt unchanged, DROP held while m_en high.
REQ-041 MBUS_TIMEOUT_EN, TIMEOUT=10, no response -> alarm at 10th REQ cycle, m_req drops, busy clears next cycle; without macro m_req held 1000 cycles.
REQ-042 rd and wr same cycle -> write performed; rd pulse during busy -> ignored, latches unchanged.
REQ-043 __rst_ low 2 cycles into REQ -> m_req 0 immediately, busy 0, no done/alarm; new rd after release completes normally.
